// File: rtl/bfs_hop_router.sv
// rtl/bfs_hop_router.sv - level-synchronous BFS shortest-hop engine over a streamed edge list
module bfs_hop_router #(
  parameter int N_NODES = 16,
  parameter int ID_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            directed,
  input  logic [ID_W-1:0] source,
  input  logic [ID_W-1:0] destination,
  output logic            out_valid,
  output logic [ID_W-1:0] cost,
  output logic            reachable
);

  typedef enum logic [1:0] {IDLE, READ, CALC, DONE} state_t;

  localparam logic [ID_W:0] N_LIM = (ID_W+1)'(N_NODES);

  state_t state, state_nx;

  // adj row v lives at adj[v*N_NODES +: N_NODES]; bit j set means edge v->j
  logic [N_NODES*N_NODES-1:0] adj;
  logic [N_NODES*N_NODES-1:0] edge_mask;
  logic [N_NODES-1:0]         visited, frontier, reach_set, next_set, src_oh, dst_oh;
  logic [ID_W-1:0]            src_r, dst_r, level, res_cost;
  logic                       dir_r, query_bad, res_reach, dst_hit, edge_ok;

  function automatic logic in_range(input logic [ID_W-1:0] id);
    return {1'b0, id} < N_LIM;
  endfunction

  // One-hot masks for the edge being streamed in; reverse direction added for undirected graphs
  always_comb begin
    edge_mask = '0;
    edge_ok   = in_range(source) && in_range(destination);
    for (int i = 0; i < N_NODES; i++) begin
      for (int j = 0; j < N_NODES; j++) begin
        edge_mask[i*N_NODES+j] = edge_ok &&
          ((source == ID_W'(i) && destination == ID_W'(j)) ||
           (!dir_r && destination == ID_W'(i) && source == ID_W'(j)));
      end
    end
  end

  // Next BFS level: union of adjacency rows of the frontier, minus already-visited nodes
  always_comb begin
    reach_set = '0;
    src_oh    = '0;
    dst_oh    = '0;
    for (int v = 0; v < N_NODES; v++) begin
      if (frontier[v]) reach_set = reach_set | adj[v*N_NODES +: N_NODES];
      src_oh[v] = (src_r == ID_W'(v));
      dst_oh[v] = (dst_r == ID_W'(v));
    end
    next_set = reach_set & ~visited;
    dst_hit  = |(visited & dst_oh);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; in_valid during CALC/DONE is ignored
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = READ;
      READ: if (!in_valid) state_nx = CALC;
      CALC: if (query_bad || dst_hit || next_set == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: query latch, adjacency build, BFS expansion and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj       <= '0;
      visited   <= '0;
      frontier  <= '0;
      level     <= '0;
      src_r     <= '0;
      dst_r     <= '0;
      dir_r     <= 1'b0;
      query_bad <= 1'b0;
      res_cost  <= '0;
      res_reach <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          adj <= '0;
          if (in_valid) begin
            src_r     <= source;
            dst_r     <= destination;
            dir_r     <= directed;
            query_bad <= !(in_range(source) && in_range(destination));
          end
        end
        READ: begin
          if (in_valid) begin
            adj <= adj | edge_mask;
          end else begin
            frontier <= src_oh;
            visited  <= src_oh;
            level    <= '0;
          end
        end
        CALC: begin
          if (query_bad) begin
            res_reach <= 1'b0;
            res_cost  <= '0;
          end else if (dst_hit) begin
            res_reach <= 1'b1;
            res_cost  <= level;
          end else if (next_set == '0) begin
            res_reach <= 1'b0;
            res_cost  <= '0;
          end else begin
            frontier <= next_set;
            visited  <= visited | next_set;
            level    <= level + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are only non-zero during the single DONE cycle
  always_comb begin
    out_valid = (state == DONE);
    cost      = out_valid ? res_cost : '0;
    reachable = out_valid & res_reach;
  end

endmodule

// File: tb/tb_bfs_hop_router.sv
// tb/tb_bfs_hop_router.sv - scoreboard bench for bfs_hop_router (16- and 10-node instances)
module tb_bfs_hop_router;

  typedef struct {
    int         which;
    logic [3:0] cost;
    logic       reach;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       directed = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] source = '0;
  logic [3:0] destination = '0;
  logic       iv16, iv10;
  logic       ov16, r16, ov10, r10;
  logic [3:0] c16, c10;

  int   checks = 0;
  int   errors = 0;
  int   rx_count = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  exp_t exp_q[$];
  int   et[$];
  int   eh[$];

  assign iv16 = in_valid & ~sel;
  assign iv10 = in_valid & sel;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bfs_hop_router #(.N_NODES(16), .ID_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .directed(directed),
    .source(source), .destination(destination),
    .out_valid(ov16), .cost(c16), .reachable(r16)
  );

  bfs_hop_router #(.N_NODES(10), .ID_W(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .directed(directed),
    .source(source), .destination(destination),
    .out_valid(ov10), .cost(c10), .reachable(r10)
  );

  task automatic check_out(input int which, input logic ov, input logic [3:0] c, input logic r);
    exp_t e;
    if (ov) begin
      rx_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out dut%0d cost=%0d reachable=%0d required no output", which, c, r);
      end else begin
        e = exp_q.pop_front();
        if (e.which != which || c !== e.cost || r !== e.reach)
        begin
          errors++;
          $display("FAIL result dut%0d cost=%0d reachable=%0d required dut%0d cost=%0d reachable=%0d",
                   which, c, r, e.which, e.cost, e.reach);
        end
        if (e.lat >= 0) begin
          checks++;
          if (cyc - fall_cyc != e.lat) begin
            errors++;
            $display("FAIL latency dut%0d got=%0d required=%0d", which, cyc - fall_cyc, e.lat);
          end
        end
      end
    end else begin
      checks++;
      if (c !== 4'd0 || r !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs dut%0d cost=%0d reachable=%0d required 0 0", which, c, r);
      end
    end
  endtask

  // Monitor: compare every presented result against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check_out(16, ov16, c16, r16);
      check_out(10, ov10, c10, r10);
    end
  end

  task automatic add_edge(input int t, input int h);
    et.push_back(t);
    eh.push_back(h);
  endtask

  task automatic send_frame(input int which, input logic dir, input int qs, input int qd,
                            input bit expect_it, input logic [3:0] xc, input logic xr,
                            input int xl);
    exp_t e;
    @(negedge clk);
    sel         = (which == 10);
    in_valid    = 1'b1;
    directed    = dir;
    source      = 4'(qs);
    destination = 4'(qd);
    for (int i = 0; i < et.size(); i++) begin
      @(negedge clk);
      directed    = ~dir;
      source      = 4'(et[i]);
      destination = 4'(eh[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    fall_cyc = cyc;
    if (expect_it) begin
      e.which = which;
      e.cost  = xc;
      e.reach = xr;
      e.lat   = xl;
      exp_q.push_back(e);
    end
    et.delete();
    eh.delete();
  endtask

  task automatic wait_result(input int start, input string name);
    int n = 0;
    while (rx_count == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (rx_count == start) begin
      checks++;
      errors++;
      $display("FAIL timeout %s got no out_valid required one result", name);
    end
  endtask

  task automatic run(input int which, input logic dir, input int qs, input int qd,
                     input logic [3:0] xc, input logic xr, input int xl, input string name);
    int start;
    start = rx_count;
    send_frame(which, dir, qs, qd, 1'b1, xc, xr, xl);
    wait_result(start, name);
  endtask

  initial begin
    int start;
    #2;
    checks++;
    if (ov16 !== 1'b0 || c16 !== 4'd0 || r16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16 out_valid=%0b cost=%0d reachable=%0b required 0 0 0", ov16, c16, r16);
    end
    checks++;
    if (ov10 !== 1'b0 || c10 !== 4'd0 || r10 !== 1'b0) begin
      errors++;
      $display("FAIL reset10 out_valid=%0b cost=%0d reachable=%0b required 0 0 0", ov10, c10, r10);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    add_edge(0, 1); add_edge(1, 2); add_edge(2, 3);
    run(16, 1'b0, 0, 3, 4'd3, 1'b1, 5, "chain_undirected");

    add_edge(0, 1); add_edge(1, 2); add_edge(2, 3);
    run(16, 1'b1, 3, 0, 4'd0, 1'b0, 2, "chain_directed_rev");

    add_edge(0, 1); add_edge(1, 2); add_edge(2, 3);
    run(16, 1'b1, 0, 3, 4'd3, 1'b1, 5, "chain_directed_fwd");

    run(16, 1'b0, 5, 5, 4'd0, 1'b1, 2, "self_query");

    for (int i = 1; i < 16; i++) add_edge(0, i);
    add_edge(15, 7);
    run(16, 1'b0, 7, 1, 4'd2, 1'b1, 4, "star");

    add_edge(0, 1); add_edge(2, 3);
    run(16, 1'b0, 0, 3, 4'd0, 1'b0, 3, "disjoint");

    // abort a search with reset; no result may appear
    add_edge(0, 1); add_edge(1, 2); add_edge(2, 3);
    start = rx_count;
    send_frame(16, 1'b0, 0, 3, 1'b0, 4'd0, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rx_count != start) begin
      errors++;
      $display("FAIL reset_abort results=%0d required 0", rx_count - start);
    end

    add_edge(0, 1);
    run(16, 1'b0, 0, 1, 4'd1, 1'b1, 3, "after_reset");
    add_edge(0, 1);
    run(16, 1'b0, 0, 3, 4'd0, 1'b0, 3, "no_stale_edges");

    add_edge(12, 3);
    for (int i = 0; i < 9; i++) add_edge(i, i + 1);
    run(10, 1'b0, 0, 9, 4'd9, 1'b1, 11, "n10_chain");

    add_edge(0, 1);
    run(10, 1'b0, 0, 12, 4'd0, 1'b0, -1, "n10_bad_query");

    add_edge(3, 4);
    run(10, 1'b0, 4, 3, 4'd1, 1'b1, 3, "n10_back_to_back");

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
